// File: rtl/lb_uart_tx.sv
// lb_uart_tx: localbus TX FIFO feeding an 8N1 UART serializer.
// Define UART_TX_PARITY_EN for an even-parity bit (8E1 frames).
module lb_uart_tx #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0300,
  parameter int          DEPTH     = 16,
  parameter logic [15:0] DIV_RST   = 16'd867
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] qin,
  input  logic [3:0]      we,
  output logic [XLEN-1:0] qout,
  output logic            uart_tx
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     lim_q, lim_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic [AW-1:0]   wp_q, wp_d;
  logic [AW-1:0]   rp_q, rp_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     div_q, div_d;
  logic [XLEN-1:0] qout_q, qout_d;
  logic [7:0]      mem_q [DEPTH];

  logic            hit, push, push_ok, pop, clr;
  logic            full, empty, bit_end, busy;
  logic [1:0]      sel;
  logic [7:0]      head;
  logic [XLEN-1:0] status;
  logic            unused_bits;

  assign hit     = addr[XLEN-1:4] == BASE_ADDR[XLEN-1:4];
  assign sel     = addr[3:2];
  assign full    = count_q == CW'(DEPTH);
  assign empty   = count_q == '0;
  assign push    = hit && sel == 2'd0 && we[0];
  assign push_ok = push && !full;
  assign clr     = hit && sel == 2'd1 && we[0] && qin[3];
  assign head    = mem_q[rp_q];
  assign bit_end = cnt_q == lim_q;
  assign unused_bits = ^{addr[1:0], qin[XLEN-1:16], we[3:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lim_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      div_q   <= DIV_RST;
      qout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      div_q   <= div_d;
      qout_q  <= qout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= qin[7:0];
  end

  // Bit length is latched at each bit boundary from BAUDDIV.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    pop     = 1'b0;
    if (state_q != S_IDLE) begin
      if (bit_end) begin
        cnt_d = '0;
        lim_d = div_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
    unique case (state_q)
      S_IDLE: begin
        if (!empty) pop = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          sh_d  = {1'b0, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
      S_PAR: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (!empty) pop = 1'b1;
          else state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      state_d = S_START;
      sh_d    = head;
      par_d   = ^head;
      cnt_d   = '0;
      lim_d   = div_q;
    end
  end

  always_comb begin
    tx_d = 1'b1;
    busy = state_q != S_IDLE;
    unique case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = sh_q[0];
      S_PAR:   tx_d = par_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    div_d   = div_q;
    if (push_ok) wp_d = wp_q + AW'(1);
    if (pop) rp_d = rp_q + AW'(1);
    if (push_ok && !pop) count_d = count_q + CW'(1);
    if (!push_ok && pop) count_d = count_q - CW'(1);
    if (push && full) ovf_d = 1'b1;
    else if (clr) ovf_d = 1'b0;
    if (hit && sel == 2'd2) begin
      if (we[0]) div_d[7:0]  = qin[7:0];
      if (we[1]) div_d[15:8] = qin[15:8];
    end
  end

  always_comb begin
    status         = '0;
    status[0]      = busy;
    status[1]      = full;
    status[2]      = empty;
    status[3]      = ovf_q;
    status[8 +: CW] = count_q;
    qout_d = '0;
    if (hit) begin
      unique case (sel)
        2'd1:    qout_d = status;
        2'd2:    qout_d = {{(XLEN-16){1'b0}}, div_q};
        default: qout_d = '0;
      endcase
    end
  end

  assign qout    = qout_q;
  assign uart_tx = tx_q;
endmodule

// File: tb/tb_lb_uart_tx.sv
// tb_lb_uart_tx: directed bench for lb_uart_tx.
// A free-running receiver decodes uart_tx frames into a queue.
module tb_lb_uart_tx;
  localparam logic [31:0] BASE = 32'h0000_0300;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] qin = '0;
  logic [3:0]  we = '0;
  logic [31:0] qout;
  logic        uart_tx;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          wr_cyc = 0;
  int          nb = 868;
  int          rx_err = 0;
  logic [7:0]  rx_q[$];
  int          st_q[$];
  logic [31:0] rd;

  lb_uart_tx #(
    .XLEN(32), .BASE_ADDR(BASE), .DEPTH(DEPTH), .DIV_RST(16'd867)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .qin(qin),
    .we(we), .qout(qout), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] w);
    @(negedge clk);
    addr = a;
    qin = d;
    we = w;
    @(posedge clk);
    #1;
    wr_cyc = cyc;
    we = '0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    we = '0;
    @(posedge clk);
    #1;
    d = qout;
  endtask

  task automatic wait_rx(input int n);
    int k = 0;
    while (rx_q.size() < n && k < 20000) begin
      @(posedge clk);
      k++;
    end
    chk("rx_count", rx_q.size(), n);
  endtask

  initial begin : rx
    int b;
    logic [7:0] d;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && uart_tx === 1'b0) begin
        b = nb;
        st_q.push_back(cyc);
        repeat (b / 2) @(posedge clk);
        #1;
        if (uart_tx !== 1'b0) rx_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (b) @(posedge clk);
          #1;
          d[i] = uart_tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (b) @(posedge clk);
        #1;
        if (uart_tx !== ^d) rx_err++;
`endif
        repeat (b) @(posedge clk);
        #1;
        if (uart_tx !== 1'b1) rx_err++;
        rx_q.push_back(d);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    chk("rst_tx", 32'(uart_tx), 32'h1);
    bus_rd(BASE + 32'h4, rd);
    chk("rst_status", rd, 32'h0000_0004);
    bus_rd(BASE + 32'h8, rd);
    chk("rst_div", rd, 32'd867);

    bus_wr(BASE + 32'h8, 32'h0000_0003, 4'b0011);
    nb = 4;
    bus_rd(BASE + 32'h8, rd);
    chk("div3", rd, 32'h3);

    bus_wr(BASE + 32'h0, 32'hFFFF_FF55, 4'b1111);
    wait_rx(1);
    chk("byte55", 32'(rx_q[0]), 32'h55);
    chk("latency", 32'(st_q[0] - wr_cyc), 32'd2);
    repeat (10) @(posedge clk);
    chk("idle_tx", 32'(uart_tx), 32'h1);
    rx_q.delete();
    st_q.delete();

    bus_wr(BASE + 32'h0, 32'h0000_00A5, 4'b0001);
    bus_wr(BASE + 32'h0, 32'h0000_003C, 4'b0001);
    bus_rd(BASE + 32'h4, rd);
    chk("cnt1", rd, 32'h0000_0101);
    wait_rx(2);
    chk("b2b_0", 32'(rx_q[0]), 32'hA5);
    chk("b2b_1", 32'(rx_q[1]), 32'h3C);
    chk("b2b_gap", 32'(st_q[1] - st_q[0]), 32'(FB * 4));
    repeat (20) @(posedge clk);
    rx_q.delete();
    st_q.delete();

    bus_wr(BASE + 32'h0, 32'h0000_00FF, 4'b0001);
    for (int i = 0; i <= DEPTH; i++)
      bus_wr(BASE + 32'h0, 32'h10 + 32'(i), 4'b0001);
    bus_rd(BASE + 32'h4, rd);
    chk("ovf_status", rd, (32'(DEPTH) << 8) | 32'hB);
    bus_wr(BASE + 32'h4, 32'h0000_0008, 4'b0001);
    bus_rd(BASE + 32'h4, rd);
    chk("ovf_clr", rd, (32'(DEPTH) << 8) | 32'h3);
    wait_rx(DEPTH + 1);
    chk("fifo_dummy", 32'(rx_q[0]), 32'hFF);
    for (int i = 0; i < DEPTH; i++)
      chk("fifo_order", 32'(rx_q[i + 1]), 32'h10 + 32'(i));
    repeat (100) @(posedge clk);
    chk("fifo_nodrop", rx_q.size(), DEPTH + 1);
    bus_rd(BASE + 32'h4, rd);
    chk("drained", rd, 32'h0000_0004);
    rx_q.delete();
    st_q.delete();

    bus_wr(BASE + 32'h8, 32'h0000_1200, 4'b0010);
    bus_rd(BASE + 32'h8, rd);
    chk("lane1", rd, 32'h0000_1203);
    bus_wr(BASE + 32'hC, 32'hFFFF_FFFF, 4'b1111);
    bus_rd(BASE + 32'hC, rd);
    chk("rsvd", rd, 32'h0);
    bus_rd(BASE + 32'h8, rd);
    chk("rsvd_nowr", rd, 32'h0000_1203);
    bus_rd(BASE + 32'h10, rd);
    chk("miss", rd, 32'h0);
    bus_rd(BASE + 32'h0, rd);
    chk("txdata_rd", rd, 32'h0);

    bus_wr(BASE + 32'h8, 32'h0, 4'b0011);
    nb = 1;
    bus_wr(BASE + 32'h0, 32'h0000_00C3, 4'b0001);
    wait_rx(1);
    chk("div0", 32'(rx_q[0]), 32'hC3);
    repeat (20) @(posedge clk);
    rx_q.delete();
    st_q.delete();

    bus_wr(BASE + 32'h8, 32'h3, 4'b0011);
    nb = 4;
    bus_wr(BASE + 32'h0, 32'h0000_0081, 4'b0001);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_tx", 32'(uart_tx), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("async_tx", 32'(uart_tx), 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    rx_q.delete();
    st_q.delete();
    rx_err = 0;
    nb = 868;
    bus_rd(BASE + 32'h4, rd);
    chk("post_rst", rd, 32'h0000_0004);
    bus_rd(BASE + 32'h8, rd);
    chk("post_div", rd, 32'd867);
    repeat (300) @(posedge clk);
    chk("no_residual", rx_q.size(), 0);
    chk("post_tx", 32'(uart_tx), 32'h1);
    chk("frame_err", rx_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
